wb_sram_ctrl: RTL

Wishbone B4 classic slave that owns read/write port 0 of `sram_wrapper` and turns bus cycles into single-port SRAM accesses. Port 0 has no byte-write mask, so partial-word writes are done as read-modify-write. Sits between the SoC Wishbone interconnect (already address-decoded) and the SRAM macro; CLK also drives the macro's `clk0`.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_byte_merge.sv | 22 ++
 rtl/wb_sram_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the Wishbone SRAM port-0 controller
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam logic [3:0] SEL_FULL = 4'hF;
    localparam logic [3:0] SEL_NONE = 4'h0;

endpackage

// File: rtl/sram_byte_merge.sv
// rtl/sram_byte_merge.sv - combinational per-lane merge of write data over SRAM read data
module sram_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   dout,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] sel,
    output logic [DATA_W-1:0]   merged
);

    localparam int LANES = DATA_W / 8;

    always_comb begin
        merged = dout;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone classic slave driving SRAM port 0, partial writes done as read-modify-write
module wb_sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                sram_csb0,
    output logic                sram_web0,
    output logic [ADDR_W-1:0]   sram_addr0,
    output logic [DATA_W-1:0]   sram_din0,
    input  logic [DATA_W-1:0]   sram_dout0
);

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     adr_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic                  we_q;
    logic [DATA_W-1:0]     merged;
    logic                  req;

    // Byte-offset and above-window address bits alias onto the SRAM word space.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;

    sram_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .dout   (sram_dout0),
        .wdata  (dat_q),
        .sel    (sel_q),
        .merged (merged)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!wb_we_i)                  state_nxt = RD;
                    else if (wb_sel_i == SEL_FULL) state_nxt = WR;
                    else if (wb_sel_i == SEL_NONE) state_nxt = ACK;
                    else                           state_nxt = RD;
                end
            end
            RD:      state_nxt = RDW;
            RDW:     state_nxt = we_q ? WR : ACK;
            WR:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = adr_q;
        sram_din0  = dat_q;
        wb_ack_o   = 1'b0;
        case (state)
            RD:      sram_csb0 = 1'b0;
            WR: begin
                sram_csb0 = 1'b0;
                sram_web0 = 1'b0;
            end
            ACK:     wb_ack_o = wb_cyc_i;
            default: ;
        endcase
    end

    // dat_q carries the write word and is overwritten with the merged word in RDW.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            if (state == IDLE && req) begin
                adr_q <= wb_adr_i[ADDR_W+1:2];
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
            end
            if (state == RDW) begin
                if (we_q) begin
                    dat_q <= merged;
                end else begin
                    wb_dat_o <= sram_dout0;
                end
            end
        end
    end

endmodule
